// File: rtl/uart_pixel_loader.sv
// Packs the uart_rx byte stream into multi-channel pixels and writes them
// sequentially into the frame RAM, with frame handshake, timeout resync and an activity LED.
module uart_pixel_loader #(
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned CH_BITS      = 8,
  parameter int unsigned IMG_W        = 160,
  parameter int unsigned IMG_H        = 120,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned TIMEOUT_CLKS = 52080,
  parameter int unsigned LED_HOLD     = 2500000
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Rx_DV,
  input  logic [7:0]                   i_Rx_Byte,
  input  logic                         i_Frame_Ack,
  output logic                         o_Wr_En,
  output logic [ADDR_W-1:0]            o_Wr_Addr,
  output logic [CHANNELS*CH_BITS-1:0]  o_Wr_Data,
  output logic                         o_Frame_Done,
  output logic                         o_Busy,
  output logic                         o_Err_Timeout,
  output logic                         o_Led
);

  localparam int unsigned PIX_W  = CHANNELS * CH_BITS;
  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned LED_W  = $clog2(LED_HOLD + 1);
  localparam int unsigned N_PIX  = IMG_W * IMG_H;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [TO_W-1:0]     idle_q, idle_d;
  logic [LED_W-1:0]    led_cnt_q, led_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]    wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                led_q, led_d;

  logic                accept;
  logic                fire;
  logic [CH_W-1:0]     ch_eff;

  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    addr_d    = addr_q;
    pix_d     = pix_q;
    idle_d    = '0;
    led_cnt_d = led_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    accept    = 1'b0;
    fire      = 1'b0;
    ch_eff    = ch_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV) begin
          state_d = S_RECV;
          accept  = 1'b1;
        end
      end
      S_RECV: begin
        // A timeout discards the partial pixel first, so a byte arriving in
        // the same cycle lands in slot 0 of a fresh pixel.
        fire = (idle_q == TO_W'(TIMEOUT_CLKS)) && (ch_cnt_q != '0);
        if (fire) begin
          err_d    = 1'b1;
          ch_eff   = '0;
          ch_cnt_d = '0;
        end
        accept = i_Rx_DV;
        if (i_Rx_DV)
          idle_d = '0;
        else if (idle_q != TO_W'(TIMEOUT_CLKS))
          idle_d = idle_q + 1'b1;
        else
          idle_d = idle_q;
      end
      S_DONE: begin
        if (i_Frame_Ack) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      led_cnt_d = LED_W'(LED_HOLD);
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (CH_W'(k) == ch_eff)
          pix_d[(CHANNELS-1-k)*CH_BITS +: CH_BITS] = i_Rx_Byte[7 -: CH_BITS];
      end
      if (ch_eff == CH_W'(CHANNELS - 1)) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = pix_d;
        ch_cnt_d  = '0;
        if (addr_q == ADDR_W'(N_PIX - 1)) begin
          state_d = S_DONE;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + 1'b1;
        end
      end else begin
        ch_cnt_d = ch_eff + 1'b1;
      end
    end else if (led_cnt_q != '0) begin
      led_cnt_d = led_cnt_q - 1'b1;
    end

    busy_d = (state_d == S_RECV);
    done_d = (state_d == S_DONE);
    led_d  = (led_cnt_d != '0);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      ch_cnt_q  <= '0;
      addr_q    <= '0;
      pix_q     <= '0;
      idle_q    <= '0;
      led_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      addr_q    <= addr_d;
      pix_q     <= pix_d;
      idle_q    <= idle_d;
      led_cnt_q <= led_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      led_q     <= led_d;
    end
  end

  assign o_Wr_En       = wr_en_q;
  assign o_Wr_Addr     = wr_addr_q;
  assign o_Wr_Data     = wr_data_q;
  assign o_Frame_Done  = done_q;
  assign o_Busy        = busy_q;
  assign o_Err_Timeout = err_q;
  assign o_Led         = led_q;

endmodule
